// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master.
// Access-size codes, FSM encoding and request fault decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP,
        RESP_F
    } state_e;

    function automatic logic f3_fault(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic illegal;
        logic misal;
        illegal = 1'b1;
        misal   = 1'b0;
        unique case (1'b1)
            (f3 == F3_B):  illegal = 1'b0;
            (f3 == F3_BU): illegal = we;
            (f3 == F3_H): begin
                illegal = 1'b0;
                misal   = off[0];
            end
            (f3 == F3_HU): begin
                illegal = we;
                misal   = off[0];
            end
            (f3 == F3_W): begin
                illegal = 1'b0;
                misal   = (off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        return illegal | misal;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and
// store byte/halfword merge into a read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rd_i,
    input  logic [31:0] wd_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [31:0] rd_b;
    logic [31:0] rd_h;

    assign sh_b = {off_i, 3'b000};
    assign sh_h = {off_i[1], 4'b0000};
    assign rd_b = rd_i >> sh_b;
    assign rd_h = rd_i >> sh_h;

    always_comb begin
        ld_o = rd_i;
        unique case (1'b1)
            (funct3_i == F3_B):  ld_o = {{24{rd_b[7]}}, rd_b[7:0]};
            (funct3_i == F3_BU): ld_o = {24'b0, rd_b[7:0]};
            (funct3_i == F3_H):  ld_o = {{16{rd_h[15]}}, rd_h[15:0]};
            (funct3_i == F3_HU): ld_o = {16'b0, rd_h[15:0]};
            default:             ld_o = rd_i;
        endcase
    end

    always_comb begin
        st_o = wd_i;
        unique case (1'b1)
            (funct3_i == F3_B):
                st_o = (rd_i & ~(32'h0000_00FF << sh_b))
                     | ({24'b0, wd_i[7:0]} << sh_b);
            (funct3_i == F3_H):
                st_o = (rd_i & ~(32'h0000_FFFF << sh_h))
                     | ({16'b0, wd_i[15:0]} << sh_h);
            default: st_o = wd_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-only data memory; sub-word
// stores become read-modify-write, faults answer in one cycle.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        mem_we_q;
    logic [31:0] mem_a_q;
    logic [31:0] mem_wd_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;

    logic        oor;
    logic        fault;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign oor   = CHECK_RANGE && ((req_addr >> MEM_AW) != 32'd0);
    assign fault = oor | f3_fault(req_we, req_funct3, req_addr[1:0]);

    // Gated by rstn so the producer sees no accept while held in reset.
    assign req_ready = rstn && (state_q == IDLE);

    lsu_lane_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .rd_i     (mem_rd),
        .wd_i     (wdata_q),
        .ld_o     (ld_data),
        .st_o     (st_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            f3_q        <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (fault) begin
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            state_q     <= RESP_F;
                        end else begin
                            mem_a_q <= {req_addr[31:2], 2'b00};
                            if (!req_we) begin
                                state_q <= LOAD;
                            end else if (req_funct3 == F3_W) begin
                                mem_we_q <= 1'b1;
                                mem_wd_q <= req_wdata;
                                state_q  <= WRITE;
                            end else begin
                                state_q <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata_q <= ld_data;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RMW_RD: begin
                    mem_wd_q <= st_data;
                    mem_we_q <= 1'b1;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP:    state_q <= IDLE;
                RESP_F:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_a     = mem_a_q;
    assign mem_wd    = mem_wd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and random bench for lsu_mem_master against a
// byte-array memory model.
module tb_lsu_mem_master;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] dmem [64];
    logic [7:0]  rmem [256];

    lsu_mem_master #(.MEM_AW(8), .CHECK_RANGE(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = dmem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
    endfunction

    task automatic do_req(input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got, output logic gflt);
        int sz, lat, we_cnt, we_cyc, exp_lat, exp_we_cyc, n;
        bit legal, flt;
        logic [31:0] exp_rd, exp_wd, got_a, got_wd;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        flt = !legal || (addr % sz != 0) || (addr > 32'd255);
        exp_rd = '0;
        exp_wd = '0;
        if (!flt && !we) begin
            for (int i = 0; i < sz; i++)
                exp_rd |= 32'(rmem[int'(addr) + i]) << (8 * i);
            if (!f3[2] && sz < 4 && exp_rd[8*sz-1])
                exp_rd |= 32'hFFFF_FFFF << (8 * sz);
        end
        if (!flt && we) begin
            for (int i = 0; i < sz; i++)
                rmem[int'(addr) + i] = 8'(wd >> (8 * i));
            exp_wd = ref_word(int'(addr) & ~3);
        end
        exp_lat    = flt ? 1 : (!we ? 2 : (sz == 4 ? 2 : 3));
        exp_we_cyc = (we && !flt) ? (sz == 4 ? 1 : 2) : 0;

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", req_ready, 1);
        chk("rsp_one_pulse", rsp_valid, 0);
        @(posedge clk);
        lat = 0; we_cnt = 0; we_cyc = 0;
        got = 'x; gflt = 1'bx; got_a = '0; got_wd = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("busy_ready", req_ready, 0);
            if (mem_we) begin
                we_cnt++;
                we_cyc = c;
                got_a  = mem_a;
                got_wd = mem_wd;
            end
            if (rsp_valid) begin
                lat  = c;
                got  = rsp_rdata;
                gflt = rsp_fault;
                break;
            end
        end
        req_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("fault", gflt, flt);
        chk("rdata", got, exp_rd);
        chk("we_count", we_cnt, (exp_we_cyc != 0) ? 1 : 0);
        if (exp_we_cyc != 0) begin
            chk("we_cycle", we_cyc, exp_we_cyc);
            chk("we_addr", got_a, addr & ~32'd3);
            chk("we_data", got_wd, exp_wd);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        f;
        logic [31:0] a, w;
        logic [2:0]  f3;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int k = 0; k < 4; k++) rmem[4*i+k] = 8'(w >> (8 * k));
        end
        dmem[4] = 32'h8899AABB;
        rmem[16] = 8'hBB; rmem[17] = 8'hAA;
        rmem[18] = 8'h99; rmem[19] = 8'h88;

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_fault", rsp_fault, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wd", mem_wd, 0);
        rstn = 1'b1;

        do_req(0, 3'b000, 32'h11, 0, r, f); chk("lb_11", r, 32'hFFFFFFAA);
        do_req(0, 3'b100, 32'h11, 0, r, f); chk("lbu_11", r, 32'h000000AA);
        do_req(0, 3'b001, 32'h12, 0, r, f); chk("lh_12", r, 32'hFFFF8899);
        do_req(0, 3'b101, 32'h12, 0, r, f); chk("lhu_12", r, 32'h00008899);
        do_req(1, 3'b000, 32'h13, 32'h55, r, f);
        do_req(0, 3'b010, 32'h10, 0, r, f); chk("lw_10", r, 32'h5599AABB);
        do_req(1, 3'b010, 32'h14, 32'hDEADBEEF, r, f); chk("sw_rdata", r, 0);
        do_req(0, 3'b010, 32'h14, 0, r, f); chk("lw_14", r, 32'hDEADBEEF);
        do_req(0, 3'b010, 32'h12, 0, r, f); chk("lw_mis", f, 1);
        do_req(0, 3'b011, 32'h20, 0, r, f); chk("ld_f3_011", f, 1);
        do_req(0, 3'b010, 32'h100, 0, r, f); chk("lw_oor", f, 1);
        do_req(1, 3'b100, 32'h20, 32'h1, r, f); chk("sbu_illegal", f, 1);

        for (int t = 0; t < 200; t++) begin
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            f3 = 3'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), f3, a, $urandom, r, f);
        end

        w = $urandom;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h16; req_wdata = w;
        while (!req_ready) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rmw_rd_ready", req_ready, 0);
        chk("rmw_rd_we", mem_we, 0);
        #2 rstn = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("abort_ready", req_ready, 0);
        chk("abort_we", mem_we, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_rsp", rsp_valid, 0);
            chk("abort_we_hold", mem_we, 0);
        end
        rstn = 1'b1;
        #1 chk("post_rst_ready", req_ready, 1);
        @(negedge clk);
        chk("post_rst_rsp", rsp_valid, 0);
        chk("post_rst_we", mem_we, 0);
        chk("abort_word", dmem[5], ref_word(20));
        do_req(0, 3'b001, 32'h16, 0, r, f);

        for (int i = 0; i < 64; i++) chk("mem_final", dmem[i], ref_word(4 * i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
